conv_w_pixel_fifo: RTL and testbench

// First CNN conv layer with its input pixel FIFO. Accepts a raster stream of
// 28x28 unsigned 8-bit pixels, buffers them in a FIFO, computes a 5x5 valid

---
 rtl/conv_w_pixel_fifo.sv | 185 ++++++++++++++++++
 tb/tb_conv_w_pixel_fifo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_w_pixel_fifo.sv
// rtl/conv_w_pixel_fifo.sv - pixel FIFO feeding a 5x5, 6-channel valid convolution over 28x28 frames
module conv_w_pixel_fifo #(
   parameter int FIFO_DEPTH = 1024,
   parameter int IMG_W      = 28,
   parameter int K          = 5,
   parameter int NCH        = 6,
   parameter int SHIFT      = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wr_en,
   input  logic [7:0]        i_feature,
   output logic              o_fifo_full,
   output logic              o_feature_valid,
   output logic signed [7:0] o_features [0:NCH-1],
   output logic              o_frame_done
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CW    = $clog2(IMG_W);
   localparam int SW    = $clog2(K);
   localparam int ACC_W = 20;
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] LAST_POS = CW'(IMG_W - 1);
   localparam logic [CW-1:0] WIN_EDGE = CW'(K - 1);
   localparam logic [SW-1:0] LAST_SLOT = SW'(K - 1);
   localparam logic [SW-1:0] LAST_ROW  = SW'(K - 1);
   localparam logic signed [ACC_W-1:0] MAX_V = 127;
   localparam logic signed [ACC_W-1:0] MIN_V = -128;

   typedef enum logic [1:0] {IDLE, FILL, MACC, OUT} state_t;

   logic [7:0]    fifo_mem [0:FIFO_DEPTH-1];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   fifo_count;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   logic          conv_ready;
   logic [7:0]    pix;

   state_t                   state;
   logic [CW-1:0]            col;
   logic [CW-1:0]            row;
   logic [SW-1:0]            slot;
   logic [SW-1:0]            mrow;
   logic                     last_win;
   logic [7:0]               line_buf [0:K-1][0:IMG_W-1];
   logic [7:0]               win      [0:K-1][0:K-1];
   logic [7:0]               new_col  [0:K-1];
   logic signed [ACC_W-1:0]  acc      [0:NCH-1];
   logic signed [ACC_W-1:0]  row_sum  [0:NCH-1];

   function automatic logic signed [7:0] weight(input int k, input int r, input int c);
      weight = 8'((k + 1) * (r - 2) + (c - 2));
   endfunction

   function automatic logic signed [7:0] sat8(input logic signed [ACC_W-1:0] v);
      if (v > MAX_V)      sat8 = 8'sd127;
      else if (v < MIN_V) sat8 = -8'sd128;
      else                sat8 = v[7:0];
   endfunction

   assign o_fifo_full = (fifo_count == FULL_CNT);
   assign fifo_empty  = (fifo_count == '0);
   assign push        = i_wr_en & ~o_fifo_full;
   assign conv_ready  = (state == IDLE) || (state == FILL);
   assign pop         = conv_ready & ~fifo_empty;
   assign pix         = fifo_mem[rd_ptr];

   always_ff @(posedge i_clk) begin
      if (push) fifo_mem[wr_ptr] <= i_feature;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
            2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Ring of row buffers: slot holds the current row, slot+1 the oldest of the last K.
   always_ff @(posedge i_clk) begin
      if (pop) line_buf[slot][col] <= pix;
   end

   always_comb begin : col_fetch
      int s;
      logic [SW-1:0] src;
      s   = 0;
      src = '0;
      for (int r = 0; r < K - 1; r++) begin
         s = int'(slot) + 1 + r;
         if (s >= K) s = s - K;
         src = SW'(s);
         new_col[r] = line_buf[src][col];
      end
      new_col[K-1] = pix;
   end

   always_comb begin
      for (int k = 0; k < NCH; k++) begin
         row_sum[k] = '0;
         for (int c = 0; c < K; c++) begin
            row_sum[k] = row_sum[k]
                       + ACC_W'($signed({1'b0, win[mrow][c]})) * ACC_W'(weight(k, int'(mrow), c));
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state           <= IDLE;
         col             <= '0;
         row             <= '0;
         slot            <= '0;
         mrow            <= '0;
         last_win        <= 1'b0;
         o_feature_valid <= 1'b0;
         o_frame_done    <= 1'b0;
         for (int k = 0; k < NCH; k++) begin
            acc[k]        <= '0;
            o_features[k] <= '0;
         end
         for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++) win[r][c] <= '0;
      end else begin
         o_feature_valid <= 1'b0;
         o_frame_done    <= 1'b0;
         case (state)
            IDLE, FILL: begin
               if (pop) begin
                  for (int r = 0; r < K; r++) begin
                     for (int c = 0; c < K - 1; c++) win[r][c] <= win[r][c+1];
                     win[r][K-1] <= new_col[r];
                  end
                  if (col == LAST_POS) begin
                     col <= '0;
                     if (row == LAST_POS) begin
                        row  <= '0;
                        slot <= '0;
                     end else begin
                        row  <= row + CW'(1);
                        slot <= (slot == LAST_SLOT) ? '0 : slot + SW'(1);
                     end
                  end else begin
                     col <= col + CW'(1);
                  end
                  if (row >= WIN_EDGE && col >= WIN_EDGE) begin
                     state    <= MACC;
                     mrow     <= '0;
                     last_win <= (row == LAST_POS) && (col == LAST_POS);
                     for (int k = 0; k < NCH; k++) acc[k] <= '0;
                  end else begin
                     state <= FILL;
                  end
               end
            end
            MACC: begin
               for (int k = 0; k < NCH; k++) acc[k] <= acc[k] + row_sum[k];
               mrow <= mrow + SW'(1);
               if (mrow == LAST_ROW) state <= OUT;
            end
            OUT: begin
               for (int k = 0; k < NCH; k++) o_features[k] <= sat8(acc[k] >>> SHIFT);
               o_feature_valid <= 1'b1;
               o_frame_done    <= last_win;
               state           <= last_win ? IDLE : FILL;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_w_pixel_fifo.sv
// tb/tb_conv_w_pixel_fifo.sv - directed bench for conv_w_pixel_fifo
module tb_conv_w_pixel_fifo;

   localparam int NPIX = 784;
   localparam int NOUT = 576;

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_en;
   logic [7:0]        feature;
   logic              full;
   logic              valid;
   logic              done;
   logic signed [7:0] feats [0:5];

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   logic signed [7:0] cap [0:2*NOUT-1][0:5];
   int cap_n;
   int done_n;
   int done_at [0:3];
   int first_valid_cyc;
   int first_write_cyc;
   bit saw_full;

   int exp_tab [0:4][0:5] = '{
      '{0, 0, 0, 0, 0, 0},
      '{3, 3, 3, 3, 3, 3},
      '{3, 6, 9, 12, 15, 18},
      '{28, 56, 84, 112, 127, 127},
      '{-4, -7, -10, -13, -16, -19}
   };

   conv_w_pixel_fifo dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_wr_en         (wr_en),
      .i_feature       (feature),
      .o_fifo_full     (full),
      .o_feature_valid (valid),
      .o_features      (feats),
      .o_frame_done    (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (done) begin
            if (done_n < 4) done_at[done_n] = cap_n;
            done_n = done_n + 1;
         end
         if (valid) begin
            if (cap_n < 2*NOUT) for (int k = 0; k < 6; k++) cap[cap_n][k] = feats[k];
            if (cap_n == 0) first_valid_cyc = cyc;
            cap_n = cap_n + 1;
         end
      end
   end

   function automatic logic [7:0] pix(input int pat, input int y, input int x);
      case (pat)
         0:       pix = 8'd100;
         1:       pix = 8'(x);
         2:       pix = 8'(y);
         3:       pix = 8'(9 * y);
         4:       pix = 8'(27 - y);
         default: pix = 8'hFF;
      endcase
   endfunction

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; wr_en = 1'b0; feature = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      cap_n = 0; done_n = 0; saw_full = 1'b0;
      first_valid_cyc = -1; first_write_cyc = -1;
   endtask

   // Full FIFO: keep writing a poison value, which must be dropped, until space appears.
   task automatic send(input int pat, input int npix);
      int i = 0;
      int budget = 0;
      while (i < npix && budget < 40000) begin
         @(posedge clk); #1;
         budget++;
         wr_en = 1'b1;
         if (full) begin
            saw_full = 1'b1;
            feature  = 8'hFF;
         end else begin
            if (i == 0) first_write_cyc = cyc + 1;
            feature = pix(pat, (i / 28) % 28, i % 28);
            i++;
         end
      end
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic wait_outputs(input int n);
      int budget = 0;
      while (cap_n < n && budget < 15000) begin
         @(posedge clk);
         budget++;
      end
      repeat (20) @(posedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; wr_en = 1'b0; feature = '0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", full); end
      n_vec++;
      if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", valid); end
      n_vec++;
      if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
      for (int k = 0; k < 6; k++) begin
         n_vec++;
         if (feats[k] !== 8'sd0) begin
            n_err++; $display("FAIL reset_features[%0d] got %0d want 0", k, feats[k]);
         end
      end
   endtask

   task automatic test_patterns();
      logic signed [7:0] e;
      for (int p = 0; p < 5; p++) begin
         do_reset();
         send(p, NPIX);
         wait_outputs(NOUT);
         n_vec++;
         if (cap_n !== NOUT) begin n_err++; $display("FAIL pat%0d_pulses got %0d want %0d", p, cap_n, NOUT); end
         n_vec++;
         if (done_n !== 1) begin n_err++; $display("FAIL pat%0d_frame_done got %0d want 1", p, done_n); end
         n_vec++;
         if (done_n >= 1 && done_at[0] !== NOUT - 1) begin
            n_err++; $display("FAIL pat%0d_done_pos got %0d want %0d", p, done_at[0], NOUT - 1);
         end
         n_vec++;
         if (first_valid_cyc - first_write_cyc !== 123) begin
            n_err++; $display("FAIL pat%0d_latency got %0d want 123", p, first_valid_cyc - first_write_cyc);
         end
         for (int j = 0; j < NOUT && j < cap_n; j++) begin
            for (int k = 0; k < 6; k++) begin
               e = 8'(exp_tab[p][k]);
               n_vec++;
               if (cap[j][k] !== e) begin
                  n_err++; $display("FAIL pat%0d_out%0d_ch%0d got %0d want %0d", p, j, k, cap[j][k], e);
               end
            end
         end
      end
   endtask

   task automatic test_reset_midframe();
      logic signed [7:0] e;
      do_reset();
      send(4, 400);
      repeat (50) @(posedge clk);
      do_reset();
      send(3, NPIX);
      wait_outputs(NOUT);
      n_vec++;
      if (cap_n !== NOUT) begin n_err++; $display("FAIL midrst_pulses got %0d want %0d", cap_n, NOUT); end
      n_vec++;
      if (done_n !== 1) begin n_err++; $display("FAIL midrst_frame_done got %0d want 1", done_n); end
      for (int j = 0; j < NOUT && j < cap_n; j++) begin
         for (int k = 0; k < 6; k++) begin
            e = 8'(exp_tab[3][k]);
            n_vec++;
            if (cap[j][k] !== e) begin
               n_err++; $display("FAIL midrst_out%0d_ch%0d got %0d want %0d", j, k, cap[j][k], e);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic signed [7:0] e;
      do_reset();
      send(2, 2 * NPIX);
      wait_outputs(2 * NOUT);
      n_vec++;
      if (cap_n !== 2 * NOUT) begin n_err++; $display("FAIL b2b_pulses got %0d want %0d", cap_n, 2 * NOUT); end
      n_vec++;
      if (done_n !== 2) begin n_err++; $display("FAIL b2b_frame_done got %0d want 2", done_n); end
      n_vec++;
      if (done_n >= 2 && (done_at[0] !== NOUT - 1 || done_at[1] !== 2 * NOUT - 1)) begin
         n_err++; $display("FAIL b2b_done_pos got %0d,%0d want %0d,%0d", done_at[0], done_at[1], NOUT - 1, 2 * NOUT - 1);
      end
      n_vec++;
      if (saw_full !== 1'b1) begin n_err++; $display("FAIL b2b_fifo_full got %b want 1", saw_full); end
      for (int j = 0; j < 2 * NOUT && j < cap_n; j++) begin
         for (int k = 0; k < 6; k++) begin
            e = 8'(exp_tab[2][k]);
            n_vec++;
            if (cap[j][k] !== e) begin
               n_err++; $display("FAIL b2b_out%0d_ch%0d got %0d want %0d", j, k, cap[j][k], e);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; feature = '0;
      cap_n = 0; done_n = 0; saw_full = 1'b0;
      first_valid_cyc = -1; first_write_cyc = -1;
      test_reset();
      test_patterns();
      test_reset_midframe();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
